// File: rtl/noc_arb_pkg.sv
// Shared types and defaults for the NoC output-port arbiter.
// Default flit width matches the 9-bit dual-rail channel used beside the decoder output ports.
package noc_arb_pkg;

    localparam int DEF_W    = 9;
    localparam int DEF_NREQ = 2;
    localparam int TAIL_BIT = DEF_W - 1;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/out_port_arbiter_rr_pick.sv
// Combinational round-robin search: first asserted request at or after ptr, wrapping modulo NREQ.
module rr_pick
    import noc_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/out_port_arbiter.sv
// Round-robin arbiter feeding one registered output port from NREQ flit requesters.
// Define ARB_PKT_LOCK_EN for packet-lock mode; otherwise flits from different requesters interleave.
module out_port_arbiter
    import noc_arb_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    parameter  int W    = DEF_W,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic              CLK,
    input  logic              _RESET,
    input  logic [NREQ-1:0]   in_valid,
    input  logic [NREQ*W-1:0] in_data,
    output logic [NREQ-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    input  logic              out_ready,
    output logic [IDW-1:0]    grant_id,
    output logic              busy
);

    // Handshakes: a transfer happens on an edge where valid and ready are both high;
    // in_ready is a function of the current winner and the output load enable only.

    localparam int TAIL = W - 1;

    arb_state_t      state, state_nxt;
    logic [IDW-1:0]  rr_ptr, rr_ptr_nxt;
    logic [NREQ-1:0] elig, gnt;
    logic [IDW-1:0]  win;
    logic            any;
    logic            ld, xfer, rel;
    logic [W-1:0]    win_data;

    assign ld       = !out_valid || out_ready;
    assign xfer     = ld && any;
    assign win_data = in_data[int'(win)*W +: W];
    assign in_ready = ld ? gnt : '0;
    assign busy     = (state == LOCK);

`ifdef ARB_PKT_LOCK_EN
    logic [IDW-1:0] lock_id, lock_id_nxt;
    logic           win_tail;

    assign win_tail = win_data[TAIL];
    // While a packet is open only its owner may compete.
    assign elig     = (state == LOCK) ? (in_valid & (NREQ'(1) << lock_id)) : in_valid;
`else
    assign elig     = in_valid;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req (elig),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (win),
        .any (any)
    );

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        rel        = 1'b0;
`ifdef ARB_PKT_LOCK_EN
        lock_id_nxt = lock_id;
        if (xfer) begin
            case (state)
                IDLE: begin
                    if (!win_tail) begin
                        state_nxt   = LOCK;
                        lock_id_nxt = win;
                    end
                end
                LOCK: begin
                    if (win_tail) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        rel = xfer && win_tail;
`else
        state_nxt = IDLE;
        rel       = xfer;
`endif
        if (rel) begin
            rr_ptr_nxt = (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);
        end
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state  <= IDLE;
            rr_ptr <= '0;
`ifdef ARB_PKT_LOCK_EN
            lock_id <= '0;
`endif
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
`ifdef ARB_PKT_LOCK_EN
            lock_id <= lock_id_nxt;
`endif
        end
    end

    // A new flit always wins over draining, so simultaneous in/out keeps out_valid high.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            grant_id  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            grant_id  <= win;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
